// File: rtl/enc_stream_buffer_if.sv
// ----------------------------------------------------------------------------
// enc_stream_buffer_if
//   Bundles the two streaming handshakes of enc_stream_buffer.
//
//   Handshake rule (both sides): a beat transfers on a rising clock edge
//   where valid and ready are both high. A producer holds valid and its data
//   stable until the transfer. A consumer's ready never depends on that
//   same cycle's valid.
//
//   Input side  : in_valid, in_ready, in_data (lane 0 = oldest symbol)
//   Output side : out_valid, out_ready, out_data (lane 0 = oldest),
//                 out_count, out_first, out_last
//
//   Modports
//     slave  : the buffer's view (accepts input beats, produces output beats)
//     master : the environment's view (upstream source + downstream encoder)
// ----------------------------------------------------------------------------
interface enc_stream_buffer_if #(
    parameter int EGF_ORDER = 8,
    parameter int IN_SYM    = 4,
    parameter int OUT_SYM   = 8
);
    logic                                in_valid;
    logic                                in_ready;
    logic [IN_SYM-1:0][EGF_ORDER-1:0]    in_data;
    logic                                out_valid;
    logic                                out_ready;
    logic [OUT_SYM-1:0][EGF_ORDER-1:0]   out_data;
    logic [$clog2(OUT_SYM+1)-1:0]        out_count;
    logic                                out_first;
    logic                                out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/enc_stream_buffer.sv
// ----------------------------------------------------------------------------
// enc_stream_buffer
//   Symbol buffer / gearbox in front of the RS encoder core. Accepts IN_SYM
//   message symbols per input beat and re-emits them as codeword-aligned beats
//   of up to OUT_SYM symbols. The last beat of each message is partial when
//   needed so that no symbol of the next message shares a beat with it.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     bus          enc_stream_buffer_if.slave (input and output handshakes)
//     cfg_mes_len  message length; 0 or > MES_LEN_MAX selects MES_LEN_MAX.
//                  Sampled when a message's first beat leaves.
//     buf_level    stored symbol count            (ENC_BUF_LEVEL_EN only)
//     buf_hiwater  maximum buf_level since reset  (ENC_BUF_LEVEL_EN only)
//
//   Optional feature macro: ENC_BUF_LEVEL_EN adds buf_level / buf_hiwater.
//   The datapath is identical with or without it.
// ----------------------------------------------------------------------------
module enc_stream_buffer #(
    parameter int EGF_ORDER   = 8,
    parameter int IN_SYM      = 4,
    parameter int OUT_SYM     = 8,
    parameter int DEPTH       = 16,
    parameter int MES_LEN_MAX = 239
) (
    input  logic                               clk,
    input  logic                               rst,
    enc_stream_buffer_if.slave                 bus,
`ifdef ENC_BUF_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0]         buf_level,
    output logic [$clog2(DEPTH+1)-1:0]         buf_hiwater,
`endif
    input  logic [$clog2(MES_LEN_MAX+1)-1:0]   cfg_mes_len
);

    localparam int LW  = $clog2(MES_LEN_MAX + 1);
    localparam int LVW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(OUT_SYM + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // A full input beat plus a partially filled output beat must fit,
    // otherwise the buffer can deadlock waiting for a take it cannot hold.
    generate
        if (DEPTH < IN_SYM + OUT_SYM - 1) begin : g_depth_check
            $error("enc_stream_buffer: DEPTH must be >= IN_SYM + OUT_SYM - 1");
        end
    endgenerate

    typedef logic [EGF_ORDER-1:0] sym_t;

    sym_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LVW-1:0]  r_level;
    logic [LW-1:0]   r_mes_cnt;   // symbols of the current message already emitted
    logic [LW-1:0]   r_mes_len;   // length latched when the message's first beat left

    logic [LW-1:0]   w_cfg_len;
    logic [LW-1:0]   w_cur_len;
    logic [LW-1:0]   w_remain;
    logic [CW-1:0]   w_take;
    logic            w_out_valid;
    logic            w_out_last;
    logic            w_in_ready;
    logic            w_wr;
    logic            w_rd;
    logic [LVW-1:0]  w_level_next;

    // Circular pointer advance; DEPTH need not be a power of two, and
    // n never exceeds DEPTH, so a single conditional subtract suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    always_comb begin
        if (cfg_mes_len == '0 || int'(cfg_mes_len) > MES_LEN_MAX) w_cfg_len = LW'(MES_LEN_MAX);
        else                                                         w_cfg_len = cfg_mes_len;
    end

    // Mid-message the latched length rules; the live config only matters
    // for the beat that opens a message.
    assign w_cur_len = (r_mes_cnt == '0) ? w_cfg_len : r_mes_len;
    assign w_remain  = w_cur_len - r_mes_cnt;
    assign w_take    = (int'(w_remain) > OUT_SYM) ? CW'(OUT_SYM) : CW'(w_remain);

    assign w_out_valid = int'(r_level) >= int'(w_take);
    assign w_out_last  = (int'(r_mes_cnt) + int'(w_take)) == int'(w_cur_len);

    // Registered level only: freeing space on the output side this cycle
    // does not open the input until the next cycle.
    assign w_in_ready = (DEPTH - int'(r_level)) >= IN_SYM;

    assign w_wr = bus.in_valid && w_in_ready;
    assign w_rd = w_out_valid && bus.out_ready;

    assign w_level_next = LVW'(int'(r_level) + (w_wr ? IN_SYM : 0) - (w_rd ? int'(w_take) : 0));

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_count = w_take;
    assign bus.out_first = (r_mes_cnt == '0);
    assign bus.out_last  = w_out_last;

    // Read mux: lanes above take, and the whole beat while not valid,
    // are forced to zero so nothing from the next message leaks out.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < OUT_SYM; i++) begin
            if (w_out_valid && i < int'(w_take)) begin
                bus.out_data[i] = r_mem[ptr_add(r_rd_ptr, i)];
            end
        end
    end

    // Symbol storage carries no reset; reads are gated by the level.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < IN_SYM; i++) begin
                r_mem[ptr_add(r_wr_ptr, i)] <= bus.in_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_mes_cnt <= '0;
            r_mes_len <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_add(r_wr_ptr, IN_SYM);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_add(r_rd_ptr, int'(w_take));
                if (r_mes_cnt == '0) begin
                    r_mes_len <= w_cfg_len;
                end
                r_mes_cnt <= w_out_last ? '0 : r_mes_cnt + LW'(w_take);
            end
            r_level <= w_level_next;
        end
    end

`ifdef ENC_BUF_LEVEL_EN
    logic [LVW-1:0] r_hiwater;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hiwater <= '0;
        end else if (w_level_next > r_hiwater) begin
            r_hiwater <= w_level_next;
        end
    end

    assign buf_level   = r_level;
    assign buf_hiwater = r_hiwater;
`endif

endmodule

// File: tb/tb_enc_stream_buffer.sv
// ----------------------------------------------------------------------------
// tb_enc_stream_buffer
//   Bench for enc_stream_buffer (IN_SYM=4, OUT_SYM=8, DEPTH=16, EGF_ORDER=8).
//   A queue-based reference model (symbol stream + message position) predicts
//   every output each cycle; directed scenarios add fixed beat expectations.
// ----------------------------------------------------------------------------
module tb_enc_stream_buffer;

    localparam int SYM_W = 8;
    localparam int N_IN  = 4;
    localparam int N_OUT = 8;
    localparam int DEP   = 16;
    localparam int LMAX  = 239;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] cfg_mes_len;
`ifdef ENC_BUF_LEVEL_EN
    logic [4:0] buf_level;
    logic [4:0] buf_hiwater;
`endif

    enc_stream_buffer_if #(.EGF_ORDER(SYM_W), .IN_SYM(N_IN), .OUT_SYM(N_OUT)) bus_if ();

    enc_stream_buffer #(
        .EGF_ORDER  (SYM_W),
        .IN_SYM     (N_IN),
        .OUT_SYM    (N_OUT),
        .DEPTH      (DEP),
        .MES_LEN_MAX(LMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
`ifdef ENC_BUF_LEVEL_EN
        .buf_level  (buf_level),
        .buf_hiwater(buf_hiwater),
`endif
        .cfg_mes_len(cfg_mes_len)
    );

    // ---------------- scoreboard / model state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [SYM_W-1:0] exp_q[$];     // symbols stored, oldest first
    logic [31:0] beat_q[$];         // observed beats: {first, last, count, lane0}
    int          msg_pos;           // symbols of current message already emitted
    int          msg_len;           // length fixed when the message started
    int          hi_max;
    bit          accepted;
    logic [7:0]  next_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_len(input int c);
        return (c == 0 || c > LMAX) ? LMAX : c;
    endfunction

    function automatic int model_len();
        return (msg_pos == 0) ? clamp_len(int'(cfg_mes_len)) : msg_len;
    endfunction

    function automatic int model_take();
        int r;
        r = model_len() - msg_pos;
        return (r > N_OUT) ? N_OUT : r;
    endfunction

    function automatic logic [31:0] ramp4(input logic [7:0] v);
        return {v + 8'd3, v + 8'd2, v + 8'd1, v};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        msg_pos = 0;
        msg_len = 0;
        hi_max  = 0;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int          len;
        int          take;
        bit          ev;
        bit          eir;
        bit          wr;
        bit          rd;
        logic [63:0] ed;
        logic [31:0] beat;
        @(negedge clk);
        len  = model_len();
        take = model_take();
        ev   = exp_q.size() >= take;
        eir  = (DEP - exp_q.size()) >= N_IN;
        check("out_valid", bus_if.out_valid, ev);
        check("in_ready", bus_if.in_ready, eir);
        if (ev) begin
            ed = '0;
            for (int i = 0; i < take; i++) ed[i*8 +: 8] = exp_q[i];
            check("out_data", bus_if.out_data, ed);
            check("out_count", bus_if.out_count, take);
            check("out_first", bus_if.out_first, msg_pos == 0);
            check("out_last", bus_if.out_last, (msg_pos + take) == len);
        end
`ifdef ENC_BUF_LEVEL_EN
        check("buf_level", buf_level, exp_q.size());
        check("buf_hiwater", buf_hiwater, hi_max);
`endif
        beat = {8'(bus_if.out_first), 8'(bus_if.out_last), 8'(bus_if.out_count), bus_if.out_data[0]};
        wr = bus_if.in_valid && eir;
        rd = ev && bus_if.out_ready;
        @(posedge clk);
        if (rd) begin
            beat_q.push_back(beat);
            for (int i = 0; i < take; i++) void'(exp_q.pop_front());
            if (msg_pos == 0) msg_len = len;
            msg_pos += take;
            if (msg_pos == len) msg_pos = 0;
        end
        if (wr) begin
            for (int i = 0; i < N_IN; i++) exp_q.push_back(bus_if.in_data[i]);
        end
        if (exp_q.size() > hi_max) hi_max = exp_q.size();
        accepted = wr;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_beat(input logic [31:0] data);
        bus_if.in_data  = data;
        bus_if.in_valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 100 && !accepted; n++) cycle();
        check("push_accept", accepted, 1'b1);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic push_ramp(input int n);
        for (int k = 0; k < n; k++) begin
            push_beat(ramp4(next_val));
            next_val = next_val + 8'd4;
        end
    endtask

    task automatic drain();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [7:0] f,
                              input logic [7:0] l, input logic [7:0] c, input logic [7:0] d0);
        logic [31:0] got;
        got = 'x;
        if (idx < beat_q.size()) got = beat_q[idx];
        check(tag, got, {f, l, c, d0});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst              = 1'b1;
        cfg_mes_len      = 8'd10;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_out_valid", bus_if.out_valid, 1'b0);
        check("rst_in_ready", bus_if.in_ready, 1'b1);
        check("rst_out_data", bus_if.out_data, 64'h0);
`ifdef ENC_BUF_LEVEL_EN
        check("rst_buf_level", buf_level, 0);
        check("rst_buf_hiwater", buf_hiwater, 0);
`endif
        rst = 1'b0;

        // aligned stream, message length 10, ramp 1..20
        cfg_mes_len      = 8'd10;
        bus_if.out_ready = 1'b1;
        beat_q.delete();
        next_val = 8'd1;
        push_ramp(5);
        drain();
        check("aligned_nbeats", beat_q.size(), 4);
        check_beat("aligned_b0", 0, 8'd1, 8'd0, 8'd8, 8'd1);
        check_beat("aligned_b1", 1, 8'd0, 8'd1, 8'd2, 8'd9);
        check_beat("aligned_b2", 2, 8'd1, 8'd0, 8'd8, 8'd11);
        check_beat("aligned_b3", 3, 8'd0, 8'd1, 8'd2, 8'd19);

        // backpressure: fill to 16, release, input reopens one cycle later
        cfg_mes_len      = 8'd12;
        bus_if.out_ready = 1'b0;
        next_val = 8'd1;
        push_ramp(4);
        check("bp_in_ready_full", bus_if.in_ready, 1'b0);
`ifdef ENC_BUF_LEVEL_EN
        check("bp_level_full", buf_level, 16);
`endif
        beat_q.delete();
        bus_if.out_ready = 1'b1;
        cycle();
        check("bp_in_ready_release", bus_if.in_ready, 1'b1);
        push_ramp(5);
        drain();
        check("bp_nbeats", beat_q.size(), 6);
        check_beat("bp_b0", 0, 8'd1, 8'd0, 8'd8, 8'd1);
        check_beat("bp_b1", 1, 8'd0, 8'd1, 8'd4, 8'd9);
        check_beat("bp_b5", 5, 8'd0, 8'd1, 8'd4, 8'd33);

        // length change mid-message: 10 -> 5 after the first output beat
        cfg_mes_len      = 8'd10;
        bus_if.out_ready = 1'b1;
        beat_q.delete();
        next_val = 8'd1;
        push_ramp(2);
        for (int n = 0; n < 20 && beat_q.size() < 1; n++) cycle();
        check("lc_first_beat_seen", beat_q.size(), 1);
        cfg_mes_len = 8'd5;
        push_ramp(3);
        drain();
        check_beat("lc_b0", 0, 8'd1, 8'd0, 8'd8, 8'd1);
        check_beat("lc_b1", 1, 8'd0, 8'd1, 8'd2, 8'd9);
        check_beat("lc_b2", 2, 8'd1, 8'd1, 8'd5, 8'd11);
        check_beat("lc_b3", 3, 8'd1, 8'd1, 8'd5, 8'd16);

        // clamp: cfg 0 and 255 both mean 239 symbols
        for (int p = 0; p < 2; p++) begin
            cfg_mes_len      = (p == 0) ? 8'd0 : 8'd255;
            bus_if.out_ready = 1'b1;
            beat_q.delete();
            next_val = 8'd1;
            push_ramp(60);
            idle(4);
            check("clamp_nbeats", beat_q.size(), 30);
            check_beat("clamp_b0", 0, 8'd1, 8'd0, 8'd8, 8'd1);
            check_beat("clamp_b28", 28, 8'd0, 8'd0, 8'd8, 8'd225);
            check_beat("clamp_b29", 29, 8'd0, 8'd1, 8'd7, 8'd233);
            cfg_mes_len = 8'd1;
            drain();
            check_beat("clamp_flush", 30, 8'd1, 8'd1, 8'd1, 8'd240);
        end

        // reset mid-message at level 7, 8 symbols of the message emitted
        cfg_mes_len      = 8'd1;
        bus_if.out_ready = 1'b0;
        next_val = 8'd1;
        push_ramp(4);
        bus_if.out_ready = 1'b1;
        cycle();
        cfg_mes_len = 8'd20;
        cycle();
        bus_if.out_ready = 1'b0;
        cycle();
        check("mid_out_valid_before_rst", bus_if.out_valid, 1'b0);
`ifdef ENC_BUF_LEVEL_EN
        check("mid_level7", buf_level, 7);
`endif
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus_if.out_valid, 1'b0);
        check("mid_rst_out_data", bus_if.out_data, 64'h0);
        check("mid_rst_in_ready", bus_if.in_ready, 1'b1);
`ifdef ENC_BUF_LEVEL_EN
        check("mid_rst_buf_level", buf_level, 0);
        check("mid_rst_buf_hiwater", buf_hiwater, 0);
`endif
        model_reset();
        #2;
        rst = 1'b0;

        // fresh ramp after reset; burst to level 12 then drain
        cfg_mes_len      = 8'd8;
        bus_if.out_ready = 1'b0;
        beat_q.delete();
        next_val = 8'd1;
        push_ramp(3);
        bus_if.out_ready = 1'b1;
        cycle();
        push_ramp(1);
        drain();
        check_beat("post_rst_b0", 0, 8'd1, 8'd1, 8'd8, 8'd1);
        check("post_rst_nbeats", beat_q.size(), 2);
`ifdef ENC_BUF_LEVEL_EN
        check("hiwater_12", buf_hiwater, 12);
        check("level_drained", buf_level, 0);
`endif

        // randomized traffic with random length changes
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 5))
                    0:       cfg_mes_len = 8'd0;
                    1:       cfg_mes_len = 8'd255;
                    2:       cfg_mes_len = 8'd239;
                    default: cfg_mes_len = 8'($urandom_range(1, 40));
                endcase
            end
            bus_if.in_valid  = ($urandom_range(0, 99) < 70);
            bus_if.in_data   = $urandom;
            bus_if.out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        bus_if.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
